// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered carry, LSB first, WIDTH cycles.
// Define SERIAL_ADDSUB_ABORT_EN to add an abort input that cancels a running operation.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;
  logic              sum_bit, carry_nxt, abort_run;
  logic [WIDTH-1:0]  sum_full;

`ifdef SERIAL_ADDSUB_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    sum_bit     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_nxt   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    sum_full    = {sum_bit, sum_sr_q[WIDTH-1:1]};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_sr_d  = a;
          // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
          b_sr_d  = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (abort_run) begin
          state_d = StIdle;
        end else begin
          a_sr_d   = a_sr_q >> 1;
          b_sr_d   = b_sr_q >> 1;
          sum_sr_d = sum_full;
          carry_d  = carry_nxt;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            state_d     = StDone;
            result_d    = sum_full;
            carry_out_d = carry_nxt;
            // carry_q is the carry into the MSB at this edge.
            overflow_d  = carry_q ^ carry_nxt;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=8 and WIDTH=4 instances checked every cycle against an
// arithmetic model of A+B / A-B with cycle-count timing.
module tb_serial_addsub;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;

  logic       ready8, done8, co8, ov8;
  logic [7:0] res8;
  logic       ready4, done4, co4, ov4;
  logic [3:0] res4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .a        (a8),
    .b        (b8),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort    (abort),
`endif
    .ready    (ready8),
    .done     (done8),
    .result   (res8),
    .carry_out(co8),
    .overflow (ov8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .a        (a4),
    .b        (b4),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort    (abort),
`endif
    .ready    (ready4),
    .done     (done4),
    .result   (res4),
    .carry_out(co4),
    .overflow (ov4)
  );

  // Golden A+B / A-B from unsigned and signed integer arithmetic.
  function automatic exp_t golden(int w, logic [31:0] a, logic [31:0] b, logic s);
    longint lim, modv, av, bv, sa, sb, tr;
    exp_t   e;
    lim  = 64'sd1 <<< (w - 1);
    modv = 2 * lim;
    av   = longint'({32'd0, a}) & (modv - 1);
    bv   = longint'({32'd0, b}) & (modv - 1);
    sa   = (av >= lim) ? av - modv : av;
    sb   = (bv >= lim) ? bv - modv : bv;
    if (s) begin
      tr    = sa - sb;
      e.res = 32'((av - bv) & (modv - 1));
      e.c   = (av >= bv);
    end else begin
      tr    = sa + sb;
      e.res = 32'((av + bv) & (modv - 1));
      e.c   = ((av + bv) >= modv);
    end
    e.v = (tr >= lim) || (tr < -lim);
    return e;
  endfunction

  // Model: busy counts down from WIDTH+1 after accept; 1 means DONE, 0 means IDLE.
  int   busy8 = 0, busy4 = 0, ops8 = 0;
  exp_t pend8 = '0, cur8 = '0, pend4 = '0, cur4 = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy8 <= 0;
      cur8  <= '0;
    end else if (busy8 == 0) begin
      if (start) begin
        busy8 <= 9;
        pend8 <= golden(8, {24'd0, a8}, {24'd0, b8}, sub);
      end
    end else if (abort && busy8 > 1) begin
      busy8 <= 0;
    end else begin
      busy8 <= busy8 - 1;
      if (busy8 == 2) begin
        cur8 <= pend8;
        ops8 <= ops8 + 1;
      end
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy4 <= 0;
      cur4  <= '0;
    end else if (busy4 == 0) begin
      if (start) begin
        busy4 <= 5;
        pend4 <= golden(4, {28'd0, a4}, {28'd0, b4}, sub);
      end
    end else if (abort && busy4 > 1) begin
      busy4 <= 0;
    end else begin
      busy4 <= busy4 - 1;
      if (busy4 == 2) cur4 <= pend4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] lit_res [4] = '{8'h96, 8'hF0, 8'h7F, 8'h00};
  logic       lit_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       lit_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit         pinned = 1'b0;

  always @(negedge clock) begin
    exp_t g;
    if (!pinned) begin
      pinned <= 1'b1;
      g = golden(4, 32'h7, 32'h1, 1'b0);
      chk("pin_7p1", {g.res[29:0], g.c, g.v}, {30'h8, 1'b0, 1'b1});
      g = golden(4, 32'h0, 32'h0, 1'b1);
      chk("pin_0m0", {g.res[29:0], g.c, g.v}, {30'h0, 1'b1, 1'b0});
      g = golden(4, 32'h8, 32'h8, 1'b0);
      chk("pin_8p8", {g.res[29:0], g.c, g.v}, {30'h0, 1'b1, 1'b1});
    end
    chk("ready8",  32'(ready8), 32'(busy8 == 0));
    chk("done8",   32'(done8),  32'(busy8 == 1));
    chk("result8", 32'(res8),   cur8.res);
    chk("carry8",  32'(co8),    32'(cur8.c));
    chk("ovf8",    32'(ov8),    32'(cur8.v));
    chk("ready4",  32'(ready4), 32'(busy4 == 0));
    chk("done4",   32'(done4),  32'(busy4 == 1));
    chk("result4", 32'(res4),   cur4.res);
    chk("carry4",  32'(co4),    32'(cur4.c));
    chk("ovf4",    32'(ov4),    32'(cur4.v));
    if (busy8 == 1 && ops8 >= 1 && ops8 <= 4) begin
      chk("lit_result8", 32'(res8), 32'(lit_res[ops8-1]));
      chk("lit_carry8",  32'(co8),  32'(lit_c[ops8-1]));
      chk("lit_ovf8",    32'(ov8),  32'(lit_v[ops8-1]));
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic s);
    a8    = av;
    b8    = bv;
    sub   = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'h10, 8'h20, 1'b1);
    op8(8'h80, 8'h01, 1'b1);
    op8(8'hFF, 8'h01, 1'b0);

    // start held high: accepts every WIDTH+2 cycles, operands churn every cycle
    start = 1'b1;
    repeat (35) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      sub = 1'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    repeat (12) @(negedge clock);

    // operand/start changes mid-run are ignored
    a8 = 8'h33; b8 = 8'h11; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    a8 = 8'hFF; b8 = 8'hFF; sub = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);

    // reset during RUN cycle 4
    a8 = 8'h77; b8 = 8'h19; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

`ifdef SERIAL_ADDSUB_ABORT_EN
    a8 = 8'h21; b8 = 8'h42; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (11) @(negedge clock);
    a8 = 8'h9C; b8 = 8'h05; sub = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (11) @(negedge clock);
`endif

    repeat (12) @(negedge clock);

    // WIDTH=4 exhaustive, one accept every 6 cycles
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          a4    = 4'(ai);
          b4    = 4'(bi);
          sub   = 1'(s);
          a8    = 8'($urandom);
          b8    = 8'($urandom);
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
          repeat (5) @(negedge clock);
        end
      end
    end
    repeat (12) @(negedge clock);

    // WIDTH=8 random with varying gaps, some starts landing while busy
    repeat (150) begin
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      a4    = 4'($urandom);
      b4    = 4'($urandom);
      sub   = 1'($urandom);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat ($urandom_range(3, 14)) @(negedge clock);
    end
    repeat (12) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
